// File: rtl/tm1638_pkg.sv
// rtl/tm1638_pkg.sv - shared TM1638 command constants and responder state encoding
//
// Purpose: command-class codes, data-command bit positions, the canonical
// command bytes and the responder state type, shared between the responder,
// the controller-side top and the benches.
// Ports: none (package).
package tm1638_pkg;

  // Command class lives in bits [7:6] of the first byte of every frame.
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  // Data-command and display-control bit positions.
  localparam int DATA_READ_BIT  = 1;
  localparam int DATA_FIXED_BIT = 2;
  localparam int DISP_ON_BIT    = 3;

  // Canonical command bytes.
  localparam logic [7:0] CMD_BYTE_WRITE_AUTO  = 8'h40;
  localparam logic [7:0] CMD_BYTE_READ_KEYS   = 8'h42;
  localparam logic [7:0] CMD_BYTE_WRITE_FIXED = 8'h44;
  localparam logic [7:0] CMD_BYTE_DISP_MAX    = 8'h8F;
  localparam logic [7:0] CMD_BYTE_ADDR_0      = 8'hC0;

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_CMD       = 3'd2,
    S_WRITE     = 3'd3,
    S_READ      = 3'd4,
    S_IGNORE    = 3'd5
  } resp_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - pin synchronizer with rise/fall pulse generation
//
// Purpose: brings one asynchronous pin into the clk domain and flags edges
// of the synchronized level.
// Ports:
//   clk   - system clock
//   pin   - asynchronous input pin
//   level - synchronized pin level
//   rise  - one-clk pulse on a synchronized 0->1 transition
//   fall  - one-clk pulse on a synchronized 1->0 transition
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Deliberately not reset: the chain keeps tracking the pin while the
  // consumer is held in reset, so the level is already true on release and
  // a frame in progress at that moment is seen as such.
  always_ff @(posedge clk) begin
    chain <= {chain[STAGES-2:0], pin};
    prev  <= chain[STAGES-1];
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/tm1638_responder.sv
// rtl/tm1638_responder.sv - behavioural TM1638 responder on a 3-wire LSB-first link
//
// Purpose: receives data/address/display-control commands into a display
// memory and answers key-scan reads from a snapshot of the host key image.
// Ports:
//   clk, reset_n         - system clock, synchronous active-low reset
//   sck, cs, dio_i       - serial clock (idles high), chip select (active low), data in
//   dio_o, dio_e         - serial data out and its pin output enable
//   key_data             - key image, byte 0 in [7:0] is sent first
//   display_mem          - display memory, byte i in [8*i +: 8]
//   display_on, brightness - display-control state
//   wr_strobe, wr_addr   - per-byte write pulse and address of the last write
//   frame_error          - pulse when cs rises mid-byte
//   frame_active         - synchronized cs low
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int NUM_MEM_BYTES = 16,
  parameter int KEY_BYTES     = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sck,
  input  logic                       cs,
  input  logic                       dio_i,
  output logic                       dio_o,
  output logic                       dio_e,
  input  logic [8*KEY_BYTES-1:0]     key_data,
  output logic [8*NUM_MEM_BYTES-1:0] display_mem,
  output logic                       display_on,
  output logic [2:0]                 brightness,
  output logic                       wr_strobe,
  output logic [3:0]                 wr_addr,
  output logic                       frame_error,
  output logic                       frame_active
);

  localparam int KEY_BITS = 8 * KEY_BYTES;
  localparam int OW       = $clog2(KEY_BITS + 1);

  logic sck_level_unused, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic dio_s, dio_rise_unused, dio_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .pin(sck), .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .pin(cs), .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_dio_sync (
    .clk(clk), .pin(dio_i), .level(dio_s), .rise(dio_rise_unused), .fall(dio_fall_unused)
  );

  resp_state_t           state;
  logic [2:0]            bit_cnt, bit_cnt_adv, bit_cnt_nxt;
  logic [7:0]            shift, rx_byte;
  logic                  byte_done, in_frame;
  logic [3:0]            addr;
  logic                  mode_fixed;
  logic [KEY_BITS-1:0]   key_shift;
  logic [OW-1:0]         out_cnt;

  assign in_frame = (state == S_CMD) || (state == S_WRITE) ||
                    (state == S_READ) || (state == S_IGNORE);

  // Byte assembly: LSB arrives first, so new bits enter at the top and
  // the byte is complete on the 8th rise.
  always_comb begin
    rx_byte     = {dio_s, shift[7:1]};
    byte_done   = 1'b0;
    bit_cnt_adv = bit_cnt;
    if (sck_rise && in_frame) begin
      if (bit_cnt == 3'd7) begin
        byte_done   = 1'b1;
        bit_cnt_adv = 3'd0;
      end else begin
        bit_cnt_adv = bit_cnt + 3'd1;
      end
    end
    // Any cs edge restarts the byte; bit_cnt_adv still tells whether the
    // frame ended on a byte boundary, with a coincident 8th rise counted.
    bit_cnt_nxt = (cs_fall || cs_rise) ? 3'd0 : bit_cnt_adv;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_WAIT_IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 8'd0;
      addr         <= 4'd0;
      mode_fixed   <= 1'b0;
      key_shift    <= '0;
      out_cnt      <= '0;
      display_mem  <= '0;
      display_on   <= 1'b0;
      brightness   <= 3'd0;
      wr_strobe    <= 1'b0;
      wr_addr      <= 4'd0;
      frame_error  <= 1'b0;
      frame_active <= 1'b0;
      dio_e        <= 1'b0;
      dio_o        <= 1'b1;
    end else begin
      wr_strobe    <= 1'b0;
      frame_error  <= 1'b0;
      frame_active <= ~cs_level;
      bit_cnt      <= bit_cnt_nxt;
      if (sck_rise && in_frame) shift <= rx_byte;

      case (state)
        S_WAIT_IDLE: if (cs_level) state <= S_IDLE;
        S_IDLE:      if (cs_fall) state <= S_CMD;
        S_CMD: begin
          if (byte_done) begin
            case (rx_byte[7:6])
              CMD_DATA: begin
                mode_fixed <= rx_byte[DATA_FIXED_BIT];
                if (rx_byte[DATA_READ_BIT]) begin
                  // Snapshot so a host update mid-read cannot tear the reply.
                  key_shift <= key_data;
                  out_cnt   <= '0;
                  state     <= S_READ;
                end else begin
                  state <= S_IGNORE;
                end
              end
              CMD_DISP: begin
                display_on <= rx_byte[DISP_ON_BIT];
                brightness <= rx_byte[2:0];
                state      <= S_IGNORE;
              end
              CMD_ADDR: begin
                addr  <= 4'(32'(rx_byte[3:0]) % NUM_MEM_BYTES);
                state <= S_WRITE;
              end
              default: state <= S_IGNORE;
            endcase
          end
        end
        S_WRITE: begin
          if (byte_done) begin
            for (int i = 0; i < NUM_MEM_BYTES; i++) begin
              if (addr == 4'(i)) display_mem[8*i +: 8] <= rx_byte;
            end
            wr_strobe <= 1'b1;
            wr_addr   <= addr;
            if (!mode_fixed) addr <= 4'((32'(addr) + 32'd1) % NUM_MEM_BYTES);
          end
        end
        S_READ: begin
          if (sck_fall) begin
            if (out_cnt != OW'(KEY_BITS)) begin
              dio_e     <= 1'b1;
              dio_o     <= key_shift[0];
              key_shift <= key_shift >> 1;
              out_cnt   <= out_cnt + 1'b1;
            end else begin
              dio_e <= 1'b0;
              dio_o <= 1'b1;
              state <= S_IGNORE;
            end
          end
        end
        S_IGNORE: ;
        default: state <= S_WAIT_IDLE;
      endcase

      // Frame end overrides whatever the byte handling above chose.
      if (cs_rise && in_frame) begin
        state       <= S_IDLE;
        dio_e       <= 1'b0;
        dio_o       <= 1'b1;
        frame_error <= (bit_cnt_adv != 3'd0);
      end
    end
  end

endmodule
